// File: rtl/exec_pkg.sv
// exec_pkg: shared funct codes, stage FSM states and sign-extension helper
package exec_pkg;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_MULT = 6'b011000;
    typedef enum logic [1:0] {IDLE, MUL, MUL_DONE} state_t;
    // sign-extends the low w bits of v; callers truncate to their datapath width
    function automatic logic [63:0] sign_extend(input logic [63:0] v, input int w);
        return $unsigned($signed(v << (64 - w)) >>> (64 - w));
    endfunction
endpackage

// File: rtl/exec_iter_mul.sv
// exec_iter_mul: shift-add multiplier retiring MUL_UNROLL multiplier bits per cycle (low half)
module exec_iter_mul #(
    parameter int XLEN       = 32,
    parameter int MUL_UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] mcand,
    input  logic [XLEN-1:0] mplier,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);
    localparam int STEPS = XLEN / MUL_UNROLL;
    localparam int CW    = $clog2(STEPS + 1);
    logic [XLEN-1:0] r_mcand, r_mplier, r_acc, w_acc;
    logic [CW-1:0]   r_cnt;
    always_comb begin
        w_acc = r_acc;
        for (int i = 0; i < MUL_UNROLL; i++) w_acc = w_acc + (r_mplier[i] ? r_mcand << i : '0);
    end
    assign busy = r_cnt != '0;
    assign done = r_cnt == CW'(1);
    // while stepping, expose the post-step sum so the final step lands in the same cycle
    assign product = busy ? w_acc : r_acc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (start) begin
            r_mcand  <= mcand;
            r_mplier <= mplier;
            r_acc    <= '0;
            r_cnt    <= CW'(STEPS);
        end else if (busy) begin
            r_acc    <= w_acc;
            r_mcand  <= r_mcand << MUL_UNROLL;
            r_mplier <= r_mplier >> MUL_UNROLL;
            r_cnt    <= r_cnt - CW'(1);
        end
    end
endmodule

// File: rtl/execute_pipe.sv
// execute_pipe: registered valid/ready execute stage with single-cycle ALU and iterative MULT
module execute_pipe
    import exec_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int CONST_W    = 21,
    parameter int SHAMT_W    = 5,
    parameter int MUL_UNROLL = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         function_code,
    input  logic [XLEN-1:0]    data1,
    input  logic [XLEN-1:0]    data2,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [CONST_W-1:0] constant,
    input  logic               ALUSrc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    result,
    output logic [XLEN-1:0]    extended_constant,
    output logic               overflow,
    output logic               illegal
);
    logic [XLEN-1:0]    w_op2, w_sum, w_diff, w_alu, w_ext, w_mul_prod;
    logic [XLEN-1:0]    r_result, r_ext, r_mul_ext;
    logic [SHAMT_W-1:0] w_sh;
    logic               w_alu_ovf, w_alu_ill, w_is_mul, w_slot, w_accept, w_load_alu, w_load_mul;
    logic               w_mul_busy, w_mul_done, r_out_valid, r_ovf, r_ill;
    state_t             r_state, w_state_nxt;
    assign w_op2    = ALUSrc ? data2 : XLEN'(shamt);
    assign w_sh     = w_op2[SHAMT_W-1:0];
    assign w_sum    = data1 + w_op2;
    assign w_diff   = data1 - w_op2;
    assign w_is_mul = function_code == FN_MULT;
    assign w_ext    = XLEN'(sign_extend(64'(constant), CONST_W));
    always_comb begin
        w_alu     = '0;
        w_alu_ovf = 1'b0;
        w_alu_ill = 1'b0;
        case (function_code)
            FN_ADD:  begin
                w_alu     = w_sum;
                w_alu_ovf = (data1[XLEN-1] == w_op2[XLEN-1]) && (w_sum[XLEN-1] != data1[XLEN-1]);
            end
            FN_SUB:  begin
                w_alu     = w_diff;
                w_alu_ovf = (data1[XLEN-1] != w_op2[XLEN-1]) && (w_diff[XLEN-1] != data1[XLEN-1]);
            end
            FN_AND:  w_alu = data1 & w_op2;
            FN_OR:   w_alu = data1 | w_op2;
            FN_SLT:  w_alu = XLEN'($signed(data1) < $signed(w_op2));
            FN_SLL:  w_alu = data1 << w_sh;
            FN_SRL:  w_alu = data1 >> w_sh;
            FN_SRA:  w_alu = $unsigned($signed(data1) >>> w_sh);
            FN_MULT: w_alu = '0;
            default: w_alu_ill = 1'b1;
        endcase
    end
    assign w_slot     = !r_out_valid || out_ready;
    assign in_ready   = (r_state == IDLE) && w_slot;
    assign w_accept   = in_valid && in_ready;
    assign w_load_alu = w_accept && !w_is_mul;
    assign w_load_mul = w_slot && (r_state == MUL_DONE || (r_state == MUL && w_mul_busy && w_mul_done));
    exec_iter_mul #(.XLEN(XLEN), .MUL_UNROLL(MUL_UNROLL)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_accept && w_is_mul),
        .mcand   (data1),
        .mplier  (w_op2),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_prod)
    );
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     w_state_nxt = (w_accept && w_is_mul) ? MUL : IDLE;
            MUL:      w_state_nxt = w_mul_done ? (w_slot ? IDLE : MUL_DONE) : MUL;
            MUL_DONE: w_state_nxt = w_slot ? IDLE : MUL_DONE;
            default:  w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_ext       <= '0;
            r_mul_ext   <= '0;
            r_ovf       <= 1'b0;
            r_ill       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // the immediate of a MULT is parked until its product is written out
            if (w_accept && w_is_mul) r_mul_ext <= w_ext;
            if (w_load_alu) begin
                r_result    <= w_alu;
                r_ext       <= w_ext;
                r_ovf       <= w_alu_ovf;
                r_ill       <= w_alu_ill;
                r_out_valid <= 1'b1;
            end else if (w_load_mul) begin
                r_result    <= w_mul_prod;
                r_ext       <= r_mul_ext;
                r_ovf       <= 1'b0;
                r_ill       <= 1'b0;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
    assign out_valid         = r_out_valid;
    assign result            = r_result;
    assign extended_constant = r_ext;
    assign overflow          = r_ovf;
    assign illegal           = r_ill;
endmodule
